fir_filter_seq: RTL and testbench

Parametrised, time-multiplexed FIR filter that generalises the team's fixed 16-bit `filter` block. It supports configurable data/coefficient width and tap count, runtime-loadable coefficients, a valid/ready input handshake, rounding and saturation. One shared multiplier performs one tap MAC per cycle, so the block suits low-rate sample streams in the signal-processing path.

---
 rtl/fir_filter_seq.sv | 120 ++++++++++++
 tb/tb_fir_filter_seq.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_seq.sv
// Time-multiplexed FIR filter: one shared multiplier performs one tap MAC per clock,
// with runtime-loadable coefficients, valid/ready input and round/saturate output.
module fir_filter_seq #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int OUT_SHIFT = 15,
    parameter int SATURATE  = 1,
    localparam int AW       = $clog2(TAPS),
    localparam int ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] Xn,
    input  logic                     clear,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] Yn
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Rounding bias and clamp limits live one bit wider than the accumulator so the
    // bias addition can never wrap.
    localparam logic signed [ACC_W:0] RND  = ((ACC_W+1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] YMAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] YMIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                   r_state;
    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [COEF_W-1:0] r_c [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_cnt;
    logic signed [DATA_W-1:0] r_yn;
    logic                     r_out_valid;

    logic                     w_coef_wr;
    logic signed [ACC_W-1:0]  w_prod;

    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] t;
        t = {a[ACC_W-1], a} + RND;
        return t >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_trunc(input logic signed [ACC_W:0] r);
        if (SATURATE != 0) begin
            if (r > YMAX) return YMAX[DATA_W-1:0];
            if (r < YMIN) return YMIN[DATA_W-1:0];
        end
        return r[DATA_W-1:0];
    endfunction

    assign in_ready  = (r_state == IDLE) && !clear;
    assign w_coef_wr = (r_state == IDLE) && coef_we && (int'(coef_addr) < TAPS);
    assign w_prod    = ACC_W'(r_x[r_cnt]) * ACC_W'(r_c[r_cnt]);
    assign out_valid = r_out_valid;
    assign Yn        = r_yn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_yn        <= '0;
            r_out_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_c[k] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            // A write landing on the acceptance edge is seen by the MAC that follows.
            if (w_coef_wr) begin
                r_c[coef_addr] <= coef_data;
            end
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        for (int k = 0; k < TAPS; k++) begin
                            r_x[k] <= '0;
                        end
                    end else if (in_valid) begin
                        r_x[0] <= Xn;
                        for (int k = 1; k < TAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_prod;
                    if (r_cnt == AW'(TAPS-1)) begin
                        r_cnt   <= '0;
                        r_state <= OUT;
                    end else begin
                        r_cnt <= r_cnt + AW'(1);
                    end
                end
                OUT: begin
                    r_yn        <= sat_trunc(round_shift(r_acc));
                    r_out_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_seq.sv
// Bench for fir_filter_seq: three 4-tap instances (saturating, wrapping, rounding)
// share one stimulus stream and are compared against an arithmetic reference model.
module tb_fir_filter_seq;

    localparam int TAPS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid;
    logic signed [15:0]  Xn;
    logic                clear;
    logic                coef_we;
    logic [1:0]          coef_addr;
    logic signed [15:0]  coef_data;
    logic                rdy_a, rdy_b, rdy_c;
    logic                ov_a, ov_b, ov_c;
    logic signed [15:0]  y_a, y_b, y_c;

    always #5 clk = ~clk;

    fir_filter_seq #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(0), .SATURATE(1)) u_dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .Xn(Xn),
        .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_a), .Yn(y_a));

    fir_filter_seq #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(0), .SATURATE(0)) u_dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .Xn(Xn),
        .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_b), .Yn(y_b));

    fir_filter_seq #(.DATA_W(16), .COEF_W(16), .TAPS(TAPS), .OUT_SHIFT(1), .SATURATE(1)) u_dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c), .Xn(Xn),
        .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(ov_c), .Yn(y_c));

    int     checks = 0;
    int     errors = 0;
    longint m_x [TAPS];
    longint m_c [TAPS];

    typedef struct {
        logic signed [15:0] x;
        bit                 we;
        logic [1:0]         addr;
        logic signed [15:0] data;
        bit                 mac_we;
        int                 setup;   // 1: clear pulse, 2: saturation coefs, 3: rounding coefs
        int                 ea;
        int                 eb;
        int                 ec;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint model_acc();
        longint s = 0;
        for (int k = 0; k < TAPS; k++) s += m_x[k] * m_c[k];
        return s;
    endfunction

    function automatic longint expect_y(input longint acc, input int sh, input bit sat);
        longint r;
        r = acc;
        if (sh > 0) r = r + (longint'(1) << (sh - 1));
        r = r >>> sh;
        if (sat) begin
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end else begin
            r = longint'($signed(r[15:0]));
        end
        return r;
    endfunction

    task automatic model_accept(input longint x, input bit we, input int addr, input longint data);
        if (we) m_c[addr] = data;
        for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
        m_x[0] = x;
    endtask

    task automatic write_coef(input int addr, input logic signed [15:0] data);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 2'(addr);
        coef_data = data;
        @(negedge clk);
        coef_we   = 1'b0;
        m_c[addr] = longint'(data);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        Xn       = 16'sd99;
        #1;
        chk("clear_blocks_ready", rdy_a, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clear_sample_not_taken", rdy_a, 1);
        for (int k = 0; k < TAPS; k++) m_x[k] = 0;
    endtask

    task automatic send(input logic signed [15:0] x, input bit we, input logic [1:0] addr,
                        input logic signed [15:0] data, input bit mac_we, input bit use_model,
                        input longint exp_a, input longint exp_b, input longint exp_c,
                        input string name);
        int     n;
        int     lat;
        int     pulses;
        longint ea, eb, ec, acc;
        ea = exp_a; eb = exp_b; ec = exp_c;
        @(negedge clk);
        in_valid  = 1'b1;
        Xn        = x;
        coef_we   = we;
        coef_addr = addr;
        coef_data = data;
        #1;
        n = 0;
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_a) begin
            chk({name, "_accept_timeout"}, 0, 1);
            in_valid = 1'b0;
            coef_we  = 1'b0;
            return;
        end
        model_accept(x, we, int'(addr), longint'(data));
        if (use_model) begin
            acc = model_acc();
            ea  = expect_y(acc, 0, 1'b1);
            eb  = expect_y(acc, 0, 1'b0);
            ec  = expect_y(acc, 1, 1'b1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = mac_we;
        coef_addr = 2'd0;
        coef_data = 16'sd100;
        lat    = 0;
        pulses = 0;
        for (int i = 1; i <= TAPS + 3; i++) begin
            @(negedge clk);
            if (i == TAPS) coef_we = 1'b0;
            if (ov_a | ov_b | ov_c) pulses++;
            if ((ov_a & ov_b & ov_c) && lat == 0) begin
                lat = i;
                chk({name, "_ya"}, y_a, ea);
                chk({name, "_yb"}, y_b, eb);
                chk({name, "_yc"}, y_c, ec);
                chk({name, "_ready_with_valid"}, rdy_a, 1);
            end
        end
        chk({name, "_latency"}, lat, TAPS + 1);
        chk({name, "_pulses"}, pulses, 1);
    endtask

    task automatic hold_test(input logic signed [15:0] a, input logic signed [15:0] b);
        int     n;
        longint acc;
        @(negedge clk);
        in_valid = 1'b1;
        Xn       = a;
        #1;
        n = 0;
        while (!rdy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        model_accept(a, 1'b0, 0, 0);
        acc = model_acc();
        @(negedge clk);
        Xn = b;
        n  = 0;
        while (!rdy_a && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("hold_ready_low_cycles", n, TAPS + 1);
        chk("hold_first_valid", ov_a & ov_b & ov_c, 1);
        chk("hold_first_ya", y_a, expect_y(acc, 0, 1'b1));
        chk("hold_first_yc", y_c, expect_y(acc, 1, 1'b1));
        model_accept(b, 1'b0, 0, 0);
        acc = model_acc();
        @(negedge clk);
        in_valid = 1'b0;
        chk("hold_no_double_pulse", ov_a | ov_b | ov_c, 0);
        chk("hold_second_taken", rdy_a, 0);
        n = 0;
        while (!(ov_a & ov_b & ov_c) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_second_latency", n, TAPS + 1);
        chk("hold_second_ya", y_a, expect_y(acc, 0, 1'b1));
        chk("hold_second_yb", y_b, expect_y(acc, 0, 1'b0));
    endtask

    initial begin
        int pulses;
        reset     = 1'b0;
        in_valid  = 1'b0;
        Xn        = '0;
        clear     = 1'b0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        for (int k = 0; k < TAPS; k++) begin
            m_x[k] = 0;
            m_c[k] = 0;
        end

        tbl[0]  = '{16'sd1,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 1, 1, 1};
        tbl[1]  = '{16'sd2,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 3, 3, 2};
        tbl[2]  = '{16'sd3,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 6, 6, 3};
        tbl[3]  = '{16'sd4,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 10, 10, 5};
        tbl[4]  = '{16'sd5,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 14, 14, 7};
        tbl[5]  = '{16'sd7,      1'b0, 2'd0, 16'sd0, 1'b0, 1, 7, 7, 4};
        tbl[6]  = '{16'sd1,      1'b1, 2'd0, 16'sd3, 1'b0, 0, 10, 10, 5};
        tbl[7]  = '{16'sd2,      1'b0, 2'd0, 16'sd0, 1'b1, 0, 14, 14, 7};
        tbl[8]  = '{16'sd1,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 13, 13, 7};
        tbl[9]  = '{16'sh7FFF,   1'b0, 2'd0, 16'sd0, 1'b0, 2, 32767, 1, 32767};
        tbl[10] = '{16'sh8000,   1'b0, 2'd0, 16'sd0, 1'b0, 0, -32768, -32768, -32768};
        tbl[11] = '{16'sd3,      1'b0, 2'd0, 16'sd0, 1'b0, 3, 3, 3, 2};
        tbl[12] = '{-16'sd3,     1'b0, 2'd0, 16'sd0, 1'b0, 0, -3, -3, -1};
        tbl[13] = '{16'sd2,      1'b0, 2'd0, 16'sd0, 1'b0, 0, 2, 2, 1};

        @(negedge clk);
        chk("reset_out_valid", ov_a | ov_b | ov_c, 0);
        chk("reset_yn", y_a, 0);
        reset = 1'b1;
        #1;
        chk("reset_in_ready", rdy_a, 1);

        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd1);

        for (int i = 0; i < 14; i++) begin
            case (tbl[i].setup)
                1: do_clear();
                2: begin
                    write_coef(0, 16'sh7FFF);
                    for (int k = 1; k < TAPS; k++) write_coef(k, 16'sd0);
                end
                3: write_coef(0, 16'sd1);
                default: ;
            endcase
            send(tbl[i].x, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].mac_we, 1'b0,
                 tbl[i].ea, tbl[i].eb, tbl[i].ec, $sformatf("vec%0d", i));
        end

        for (int k = 0; k < TAPS; k++) begin
            if ($urandom_range(0, 1) == 0) write_coef(k, 16'($urandom));
            else write_coef(k, 16'($signed($urandom_range(0, 511)) - 256));
        end
        for (int i = 0; i < 30; i++) begin
            send(16'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 16'($urandom), 1'($urandom_range(0, 1)), 1'b1, 0, 0, 0,
                 $sformatf("rnd%0d", i));
        end

        hold_test(16'($urandom), 16'($urandom));

        write_coef(0, 16'sd1);
        for (int k = 1; k < TAPS; k++) write_coef(k, 16'sd0);
        send(16'sd9, 1'b0, 2'd0, 16'sd0, 1'b0, 1'b0, 9, 9, 5, "pre_reset");

        @(negedge clk);
        in_valid = 1'b1;
        Xn       = 16'sd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_out_valid", ov_a | ov_b | ov_c, 0);
        chk("midreset_yn", y_a, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_in_ready", rdy_a, 1);
        pulses = 0;
        for (int i = 0; i < TAPS + 4; i++) begin
            @(negedge clk);
            if (ov_a | ov_b | ov_c) pulses++;
        end
        chk("midreset_no_stale_valid", pulses, 0);
        for (int k = 0; k < TAPS; k++) begin
            m_x[k] = 0;
            m_c[k] = 0;
        end
        send(16'sd5, 1'b0, 2'd0, 16'sd0, 1'b0, 1'b1, 0, 0, 0, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
